// File: rtl/alkshseq.sv
// rtl/alkshseq.sv - multi-cycle shift sequencer driving the ALK ALU shift ops
module alkshseq #(
    parameter int CNT_W = 6
) (
    input  logic             clk_h,
    input  logic             reset_l,
    input  logic             start_h,
    input  logic             dir_shr_h,
    input  logic [1:0]       mode_h,
    input  logic [CNT_W-1:0] count_h,
    input  logic             fill_h,
    input  logic             stall_h,
    input  logic             abort_h,
    input  logic             alu_sout_shl_h,
    input  logic             alu_sout_shr_h,
    input  logic             alu_msb_h,
    output logic             alpctl_shl_op_h,
    output logic             alpctl_shr_op_h,
    output logic             alu_sin_h,
    output logic             carry_h,
    output logic             busy_h,
    output logic             done_h
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             op_en;
    logic             shift_out;

    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
        end
    end

    // Bit leaving the ALU in the latched direction; also the rotate re-entry bit.
    assign shift_out = dir_q ? alu_sout_shr_h : alu_sout_shl_h;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        op_en   = 1'b0;
        done_h  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_h && !abort_h) begin
                    cnt_d   = count_h;
                    dir_d   = dir_shr_h;
                    mode_d  = mode_h;
                    carry_d = 1'b0;
                    state_d = (count_h != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (abort_h) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (!stall_h && cnt_q != '0) begin
                    op_en   = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    carry_d = shift_out;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_h  = !abort_h;
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        alu_sin_h = 1'b0;
        if (op_en) begin
            case (mode_q)
                2'b00:   alu_sin_h = 1'b0;
                2'b01:   alu_sin_h = dir_q ? alu_msb_h : 1'b0;
                2'b10:   alu_sin_h = shift_out;
                default: alu_sin_h = fill_h;
            endcase
        end
    end

    assign alpctl_shr_op_h = op_en & dir_q;
    assign alpctl_shl_op_h = op_en & ~dir_q;
    assign carry_h         = carry_q;
    assign busy_h          = (state_q != S_IDLE);

endmodule

// File: tb/tb_alkshseq.sv
// tb/tb_alkshseq.sv - cycle-table and directed-sequence bench for alkshseq
module tb_alkshseq;

    logic       clk_h = 1'b0;
    logic       reset_l = 1'b0;
    logic       start_h = 1'b0;
    logic       dir_shr_h = 1'b0;
    logic [1:0] mode_h = 2'b00;
    logic [5:0] count_h = 6'd0;
    logic       fill_h = 1'b0;
    logic       stall_h = 1'b0;
    logic       abort_h = 1'b0;
    logic       alu_sout_shl_h = 1'b0;
    logic       alu_sout_shr_h = 1'b0;
    logic       alu_msb_h = 1'b0;
    logic       alpctl_shl_op_h, alpctl_shr_op_h, alu_sin_h, carry_h, busy_h, done_h;

    int npass = 0;
    int ntot  = 0;

    alkshseq #(.CNT_W(6)) dut (
        .clk_h(clk_h), .reset_l(reset_l), .start_h(start_h), .dir_shr_h(dir_shr_h),
        .mode_h(mode_h), .count_h(count_h), .fill_h(fill_h), .stall_h(stall_h),
        .abort_h(abort_h), .alu_sout_shl_h(alu_sout_shl_h), .alu_sout_shr_h(alu_sout_shr_h),
        .alu_msb_h(alu_msb_h), .alpctl_shl_op_h(alpctl_shl_op_h), .alpctl_shr_op_h(alpctl_shr_op_h),
        .alu_sin_h(alu_sin_h), .carry_h(carry_h), .busy_h(busy_h), .done_h(done_h)
    );

    always #5 clk_h = ~clk_h;

    wire [5:0] outv = {alpctl_shl_op_h, alpctl_shr_op_h, alu_sin_h, carry_h, busy_h, done_h};

    typedef struct {
        logic       st, dr;
        logic [1:0] md;
        logic [5:0] cn;
        logic       fl, sl, ab, sol, sor, msb;
        logic [5:0] exp;   // {shl, shr, sin, carry, busy, done}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic dr, input logic [1:0] md, input logic [5:0] cn,
                       input logic fl, input logic sl, input logic ab, input logic sol,
                       input logic sor, input logic msb, input logic [5:0] exp);
        vec_t v;
        v.st = st; v.dr = dr; v.md = md; v.cn = cn; v.fl = fl; v.sl = sl; v.ab = ab;
        v.sol = sol; v.sor = sor; v.msb = msb; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic idle_inputs();
        start_h = 0; dir_shr_h = 0; mode_h = 0; count_h = 0; fill_h = 0; stall_h = 0;
        abort_h = 0; alu_sout_shl_h = 0; alu_sout_shr_h = 0; alu_msb_h = 0;
    endtask

    initial begin
        int ops;
        int seen_done;
        //  st dr md    cn  fl sl ab sol sor msb  shl shr sin car bsy dn
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000000);  // idle after reset
        add(1, 0, 2'd0, 5,  0, 0, 0, 0,  0,  0,  6'b000000);  // logical left 5
        add(0, 0, 2'd0, 0,  0, 0, 0, 1,  0,  0,  6'b100010);
        add(1, 0, 2'd0, 2,  0, 0, 0, 0,  0,  0,  6'b100110);  // start while busy ignored
        add(0, 0, 2'd0, 0,  0, 0, 0, 1,  0,  0,  6'b100010);
        add(0, 0, 2'd0, 0,  0, 0, 0, 1,  0,  0,  6'b100110);
        add(0, 0, 2'd0, 0,  0, 0, 0, 1,  0,  0,  6'b100110);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000111);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000100);
        add(1, 1, 2'd1, 3,  0, 0, 0, 0,  0,  1,  6'b000100);  // arithmetic right 3, one stall
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  1,  1,  6'b011010);
        add(0, 0, 2'd0, 0,  0, 1, 0, 0,  0,  1,  6'b000110);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  1,  6'b011110);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  1,  1,  6'b011010);
        add(0, 0, 2'd0, 0,  0, 1, 0, 0,  0,  0,  6'b000111);  // done despite stall
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000100);
        add(1, 0, 2'd1, 1,  0, 0, 0, 0,  0,  1,  6'b000100);  // arithmetic left fills 0
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  1,  6'b100010);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000011);
        add(1, 1, 2'd2, 3,  0, 0, 0, 0,  0,  0,  6'b000000);  // rotate right 3
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  1,  0,  6'b011010);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b010110);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  1,  0,  6'b011010);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000111);
        add(1, 0, 2'd2, 1,  0, 0, 0, 0,  0,  0,  6'b000100);  // rotate left 1
        add(0, 0, 2'd0, 0,  0, 0, 0, 1,  0,  0,  6'b101010);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000111);
        add(1, 1, 2'd3, 2,  1, 0, 0, 0,  0,  0,  6'b000100);  // external fill right 2
        add(0, 0, 2'd0, 0,  1, 0, 0, 0,  0,  0,  6'b011010);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  1,  0,  6'b010010);
        add(0, 0, 2'd0, 0,  1, 0, 0, 0,  0,  0,  6'b000111);
        add(1, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000100);  // zero count
        add(1, 0, 2'd0, 3,  0, 0, 0, 0,  0,  0,  6'b000011);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000000);
        add(1, 0, 2'd0, 3,  0, 0, 0, 0,  0,  0,  6'b000000);  // abort with stall
        add(0, 0, 2'd0, 0,  0, 0, 0, 1,  0,  0,  6'b100010);
        add(0, 0, 2'd0, 0,  0, 1, 1, 0,  0,  0,  6'b000110);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000100);
        add(1, 1, 2'd0, 1,  0, 0, 0, 0,  0,  0,  6'b000100);  // abort in DONE
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  1,  0,  6'b010010);
        add(0, 0, 2'd0, 0,  0, 0, 1, 0,  0,  0,  6'b000110);
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000100);
        add(1, 0, 2'd0, 2,  0, 0, 1, 0,  0,  0,  6'b000100);  // abort beats start in IDLE
        add(0, 0, 2'd0, 0,  0, 0, 0, 0,  0,  0,  6'b000100);

        idle_inputs();
        #1;
        chk("reset_outputs", outv, 6'b000000);
        @(negedge clk_h);
        reset_l = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_h);
            start_h = vecs[i].st; dir_shr_h = vecs[i].dr; mode_h = vecs[i].md;
            count_h = vecs[i].cn; fill_h = vecs[i].fl; stall_h = vecs[i].sl;
            abort_h = vecs[i].ab; alu_sout_shl_h = vecs[i].sol;
            alu_sout_shr_h = vecs[i].sor; alu_msb_h = vecs[i].msb;
            #1;
            chk($sformatf("vec%0d", i), outv, vecs[i].exp);
        end

        // Abort count=20 after 4 shifts; shift-outs 1,0,0,1 so carry must be 1.
        @(negedge clk_h);
        idle_inputs(); start_h = 1; count_h = 6'd20;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_h);
            idle_inputs(); alu_sout_shl_h = (i == 0 || i == 3);
            #1;
            chk($sformatf("abort20_shift%0d", i), {alpctl_shl_op_h, busy_h, done_h}, 6'b000110);
        end
        @(negedge clk_h);
        idle_inputs(); abort_h = 1;
        #1;
        chk("abort20_cycle", outv, 6'b000110);
        @(negedge clk_h);
        idle_inputs();
        #1;
        chk("abort20_after", outv, 6'b000100);

        // Count of 40 runs the full count.
        @(negedge clk_h);
        idle_inputs(); start_h = 1; dir_shr_h = 1; count_h = 6'd40;
        ops = 0; seen_done = 0;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            @(negedge clk_h);
            idle_inputs();
            #1;
            if (alpctl_shr_op_h) ops++;
            if (done_h) seen_done = 1;
        end
        chk("count40_ops", 6'(ops), 6'd40);
        chk("count40_done", 6'(seen_done), 6'd1);

        // Asynchronous reset after 3 shifts of a count-10 sequence.
        @(negedge clk_h);
        idle_inputs(); start_h = 1; count_h = 6'd10; mode_h = 2'd3; fill_h = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_h);
            idle_inputs(); fill_h = 1; alu_sout_shl_h = 1;
        end
        #1;
        chk("pre_reset", outv, 6'b101110);
        #1;
        reset_l = 1'b0;
        #1;
        chk("async_reset", outv, 6'b000000);
        @(negedge clk_h);
        #1;
        chk("in_reset", outv, 6'b000000);
        reset_l = 1'b1;
        @(negedge clk_h);
        idle_inputs(); start_h = 1; count_h = 6'd1;
        #1;
        chk("post_reset_idle", outv, 6'b000000);
        @(negedge clk_h);
        idle_inputs();
        #1;
        chk("post_reset_start", outv, 6'b100010);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
